// File: rtl/vau_latency_monitor_if.sv
// Bundle of the operation-timing handshake and record-readout signals of the
// vector accelerator latency monitor. The slave modport is the monitor side.
// The master modport is the driver side: ALU sequencing and the management core.
interface vau_latency_monitor_if #(
  parameter int CNT_W  = 33,
  parameter int OP_W   = 4,
  parameter int DROP_W = 8,
  parameter int ACC_W  = 40
);
  logic              alu_rst_i;
  logic              op_start_i;
  logic [OP_W-1:0]   op_code_i;
  logic              op_done_i;
  logic              rec_valid_o;
  logic              rec_ready_i;
  logic [OP_W-1:0]   rec_op_o;
  logic [CNT_W-1:0]  rec_cycles_o;
  logic              rec_sat_o;
  logic              busy_o;
  logic              proto_err_o;
  logic [CNT_W-1:0]  total_cycles_o;
  logic [DROP_W-1:0] drop_cnt_o;
  logic [OP_W-1:0]   hist_sel_i;
  logic [ACC_W-1:0]  hist_acc_o;

  modport master (
    output alu_rst_i, op_start_i, op_code_i, op_done_i, rec_ready_i, hist_sel_i,
    input  rec_valid_o, rec_op_o, rec_cycles_o, rec_sat_o, busy_o, proto_err_o,
           total_cycles_o, drop_cnt_o, hist_acc_o
  );

  modport slave (
    input  alu_rst_i, op_start_i, op_code_i, op_done_i, rec_ready_i, hist_sel_i,
    output rec_valid_o, rec_op_o, rec_cycles_o, rec_sat_o, busy_o, proto_err_o,
           total_cycles_o, drop_cnt_o, hist_acc_o
  );
endinterface

// File: rtl/vau_latency_monitor.sv
// Per-operation cycle-latency monitor for the vector accelerator unit.
// Each operation is timed from its start strobe to its done strobe.
// The latency and the operation code are queued in a first-word-fall-through
// record FIFO. The monitor also keeps a global active-cycle count and a count
// of records dropped because the FIFO was full.
// Optional build macro PERF_MON_HISTO_EN adds one saturating latency
// accumulator per operation code.
//
// state | meaning
// IDLE  | no operation in flight, waiting for op_start_i
// RUN   | operation in flight, lat_cnt counting edges since start
module vau_latency_monitor #(
  parameter int CNT_W      = 33,
  parameter int OP_W       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 8,
  parameter int ACC_W      = 40
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_i,
  vau_latency_monitor_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = 1 + OP_W + CNT_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  lat_cnt;
  logic [OP_W-1:0]   op_q;
  logic              busy;
  logic              proto_err;
  logic [CNT_W-1:0]  total_cnt;
  logic [DROP_W-1:0] drop_cnt;

  logic [REC_W-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [REC_W-1:0]  head;
  logic              empty, full, push, pop, wr_en;
  logic              lat_sat;
  logic [CNT_W-1:0]  lat_val;

  // The edge count stays stuck at all-ones once it saturates. The done edge
  // adds one more edge on top of lat_cnt.
  assign lat_sat = (lat_cnt == CNT_MAX);
  assign lat_val = lat_sat ? CNT_MAX : lat_cnt + 1'b1;

  // An ALU reset on the done cycle aborts the record.
  assign push  = (state == RUN) && bus.op_done_i && !bus.alu_rst_i;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.rec_ready_i;
  assign wr_en = push && (!full || pop);

  // Operation sequencer: timing of the in-flight operation and protocol watch.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      op_q      <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if ((state == RUN) && bus.op_start_i) proto_err <= 1'b1;
      if (bus.alu_rst_i) begin
        state   <= IDLE;
        lat_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.op_start_i) begin
            state   <= RUN;
            lat_cnt <= '0;
            op_q    <= bus.op_code_i;
            busy    <= 1'b1;
          end
          RUN: if (bus.op_done_i) begin
            state   <= IDLE;
            lat_cnt <= '0;
            busy    <= 1'b0;
          end else if (!lat_sat) begin
            lat_cnt <= lat_cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Active-cycle counter, cleared while the ALU is held in reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                   total_cnt <= '0;
    else if (bus.alu_rst_i)         total_cnt <= '0;
    else if (total_cnt != CNT_MAX)  total_cnt <= total_cnt + 1'b1;
  end

  // Record storage. The contents need no reset because the head is masked
  // whenever the FIFO is empty.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {lat_sat, op_q, lat_val};
  end

  // FIFO pointers and the dropped-record count. A pop frees a slot on the
  // same edge, so a push into a full FIFO that is also popped is kept.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en && (drop_cnt != DROP_MAX)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign head               = mem[rd_ptr[AW-1:0]];
  assign bus.rec_valid_o    = !empty;
  assign bus.rec_cycles_o   = empty ? '0 : head[CNT_W-1:0];
  assign bus.rec_op_o       = empty ? '0 : head[CNT_W +: OP_W];
  assign bus.rec_sat_o      = !empty && head[REC_W-1];
  assign bus.busy_o         = busy;
  assign bus.proto_err_o    = proto_err;
  assign bus.total_cycles_o = total_cnt;
  assign bus.drop_cnt_o     = drop_cnt;

`ifdef PERF_MON_HISTO_EN
  localparam int N_ACC = 1 << OP_W;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [ACC_W-1:0] acc [N_ACC];
  logic [SUM_W-1:0] acc_sum;

  assign acc_sum = {1'b0, acc[op_q]} + SUM_W'(lat_val);

  // Per-op latency totals. Dropped records still count toward these totals.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < N_ACC; i++) acc[i] <= '0;
    end else if (push) begin
      acc[op_q] <= acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
    end
  end

  assign bus.hist_acc_o = acc[bus.hist_sel_i];
`else
  logic unused_hist_sel;
  assign unused_hist_sel = ^bus.hist_sel_i;
  assign bus.hist_acc_o  = '0;
`endif
endmodule
